alu_cmd_sequencer: RTL and testbench

Upstream issue stage for the combinational 32-bit ALU (ports A, B, Operator[3:0], n[5:0], Result).
- Buffers incoming ALU commands in a small FIFO and presents one command per cycle to the ALU from a registered issue stage.
- Captures the ALU Result into a registered output stage with valid/ready backpressure.
- Turns the free-running combinational ALU into a flow-controlled, pipelined unit.

---
 rtl/alu_cmd_sequencer.sv | 168 ++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Flow-controlled issue/capture wrapper around a combinational ALU: command FIFO,
// registered issue stage and registered result stage. Optional tag path: ALU_TAG_EN.
module alu_cmd_sequencer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
`ifdef ALU_TAG_EN
  ,
  parameter int TAG_W  = 4
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [DATA_W-1:0]        cmd_a,
  input  logic [DATA_W-1:0]        cmd_b,
  input  logic [3:0]               cmd_op,
  input  logic [5:0]               cmd_n,
`ifdef ALU_TAG_EN
  input  logic [TAG_W-1:0]         cmd_tag,
  output logic [TAG_W-1:0]         res_tag,
`endif
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [3:0]               alu_op,
  output logic [5:0]               alu_n,
  input  logic [DATA_W-1:0]        alu_result,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DATA_W-1:0]        res_data,
  output logic                     res_err,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         res_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = 2 * DATA_W + 10;

  logic [ENT_W-1:0] mem_reg [DEPTH];
  logic [ENT_W-1:0] head;

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0] level_reg, level_next;

  logic              s1_valid_reg;
  logic [DATA_W-1:0] alu_a_reg;
  logic [DATA_W-1:0] alu_b_reg;
  logic [3:0]        alu_op_reg;
  logic [5:0]        alu_n_reg;

  logic              res_valid_reg;
  logic [DATA_W-1:0] res_data_reg;
  logic              res_err_reg;
  logic [CNT_W-1:0]  res_count_reg;

  logic push, pop, adv2, load1, fifo_empty, illegal_op, res_hs;

  // cmd_ready looks only at the registered level, so a full FIFO never
  // accepts a push even when a pop happens on the same edge.
  assign cmd_ready  = (level_reg < LVL_W'(DEPTH));
  assign fifo_empty = (level_reg == '0);
  assign push       = cmd_valid && cmd_ready;
  assign adv2       = s1_valid_reg && (!res_valid_reg || res_ready);
  assign load1      = !fifo_empty && (!s1_valid_reg || adv2);
  assign pop        = load1;
  assign res_hs     = res_valid_reg && res_ready;
  assign illegal_op = (alu_op_reg > 4'b1010);
  assign head       = mem_reg[rd_ptr_reg];

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg + LVL_W'(push) - LVL_W'(pop);
    if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
  end

  // Storage carries no reset; the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= {cmd_a, cmd_b, cmd_op, cmd_n};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
    end
  end

  // Issue stage: alu_* keep the last issued command while the stage is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      alu_a_reg    <= '0;
      alu_b_reg    <= '0;
      alu_op_reg   <= '0;
      alu_n_reg    <= '0;
    end else if (load1) begin
      s1_valid_reg <= 1'b1;
      {alu_a_reg, alu_b_reg, alu_op_reg, alu_n_reg} <= head;
    end else if (adv2) begin
      s1_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_err_reg   <= 1'b0;
    end else if (adv2) begin
      res_valid_reg <= 1'b1;
      res_err_reg   <= illegal_op;
      res_data_reg  <= illegal_op ? '0 : alu_result;
    end else if (res_hs) begin
      res_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_count_reg <= '0;
    end else if (res_hs) begin
      res_count_reg <= res_count_reg + CNT_W'(1);
    end
  end

`ifdef ALU_TAG_EN
  logic [TAG_W-1:0] tag_mem_reg [DEPTH];
  logic [TAG_W-1:0] s1_tag_reg;
  logic [TAG_W-1:0] res_tag_reg;

  always_ff @(posedge clk) begin
    if (push) tag_mem_reg[wr_ptr_reg] <= cmd_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_tag_reg  <= '0;
      res_tag_reg <= '0;
    end else begin
      if (load1) s1_tag_reg  <= tag_mem_reg[rd_ptr_reg];
      if (adv2)  res_tag_reg <= s1_tag_reg;
    end
  end

  assign res_tag = res_tag_reg;
`endif

  assign alu_a      = alu_a_reg;
  assign alu_b      = alu_b_reg;
  assign alu_op     = alu_op_reg;
  assign alu_n      = alu_n_reg;
  assign res_valid  = res_valid_reg;
  assign res_data   = res_data_reg;
  assign res_err    = res_err_reg;
  assign fifo_level = level_reg;
  assign res_count  = res_count_reg;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed table, multi-cycle corner sequences and a
// randomized stream checked against a queue-based scoreboard with an ALU model.
module tb_alu_cmd_sequencer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_a, cmd_b;
  logic [3:0]    cmd_op;
  logic [5:0]    cmd_n;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [3:0]    alu_op;
  logic [5:0]    alu_n;
  logic          res_valid, res_ready, res_err;
  logic [DW-1:0] res_data;
  logic [2:0]    fifo_level;
  logic [15:0]   res_count;

  logic          u2_cmd_ready, u2_res_valid, u2_res_err;
  logic [DW-1:0] u2_alu_a, u2_alu_b, u2_alu_result, u2_res_data;
  logic [3:0]    u2_alu_op;
  logic [5:0]    u2_alu_n;
  logic [2:0]    u2_fifo_level;
  logic [1:0]    u2_res_count;

`ifdef ALU_TAG_EN
  logic [3:0] cmd_tag, res_tag, u2_res_tag;
  assign cmd_tag = cmd_a[3:0] ^ cmd_b[7:4];
`endif

  // Reference ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra,
  // 8 rol, 9 ror, 10 slt; codes above 10 return junk the wrapper must hide.
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op, input logic [5:0] n);
    logic [4:0] r;
    r = n[4:0];
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << n;
      4'd6:    return a >> n;
      4'd7:    return $signed(a) >>> n;
      4'd8:    return (a << r) | (a >> (32 - r));
      4'd9:    return (a >> r) | (a << (32 - r));
      4'd10:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hA5A5A5A5;
    endcase
  endfunction

  function automatic logic [31:0] exp_of(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op, input logic [5:0] n);
    return (op > 4'd10) ? 32'd0 : alu_ref(a, b, op, n);
  endfunction

  assign alu_result    = alu_ref(alu_a, alu_b, alu_op, alu_n);
  assign u2_alu_result = alu_ref(u2_alu_a, u2_alu_b, u2_alu_op, u2_alu_n);

  alu_cmd_sequencer #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_n(cmd_n),
`ifdef ALU_TAG_EN
    .cmd_tag(cmd_tag), .res_tag(res_tag),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_n(alu_n),
    .alu_result(alu_result), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err), .fifo_level(fifo_level),
    .res_count(res_count)
  );

  alu_cmd_sequencer #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(2)) dut_cnt2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(u2_cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_n(cmd_n),
`ifdef ALU_TAG_EN
    .cmd_tag(cmd_tag), .res_tag(u2_res_tag),
`endif
    .alu_a(u2_alu_a), .alu_b(u2_alu_b), .alu_op(u2_alu_op), .alu_n(u2_alu_n),
    .alu_result(u2_alu_result), .res_valid(u2_res_valid), .res_ready(res_ready),
    .res_data(u2_res_data), .res_err(u2_res_err), .fifo_level(u2_fifo_level),
    .res_count(u2_res_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [5:0] n);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_n = n; cmd_valid = 1'b1;
  endtask

  // Scoreboard: expected results queued at every accepted command, compared in
  // order at every result handshake; also checks hold-under-backpressure.
  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [3:0]  tag;
  } exp_t;
  exp_t exp_q[$];
  int   hs_cnt = 0;
  logic hold_pending = 1'b0;
  logic [31:0] hold_data;
  logic        hold_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hs_cnt = 0;
      hold_pending = 1'b0;
    end else begin
      check("ready_vs_level", 64'(cmd_ready), 64'(fifo_level < 3'(DEPTH)));
      if (hold_pending)
        check("hold_stable", {31'd0, res_valid, res_err, res_data},
              {31'd0, 1'b1, hold_err, hold_data});
      hold_pending = res_valid && !res_ready;
      hold_data    = res_data;
      hold_err     = res_err;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_result", 64'(1), 64'(0));
        end else begin
          check("sb_data", 64'(res_data), 64'(exp_q[0].data));
          check("sb_err", 64'(res_err), 64'(exp_q[0].err));
`ifdef ALU_TAG_EN
          check("sb_tag", 64'(res_tag), 64'(exp_q[0].tag));
`endif
          void'(exp_q.pop_front());
        end
        check("sb_count", 64'(res_count), 64'(hs_cnt[15:0]));
        check("sb_count2", 64'(u2_res_count), 64'(hs_cnt[1:0]));
        hs_cnt++;
      end
      if (cmd_valid && cmd_ready) begin
        exp_t e;
        e.data = exp_of(cmd_a, cmd_b, cmd_op, cmd_n);
        e.err  = (cmd_op > 4'd10);
        e.tag  = cmd_a[3:0] ^ cmd_b[7:4];
        exp_q.push_back(e);
      end
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [5:0]  n;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;
  localparam int NV = 15;
  vec_t vecs[NV];

  logic [31:0] fa[7];
  logic [3:0]  fop[7];
  int          wrap_seq[5];

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_n = '0;

    vecs[0]  = '{32'h67085186, 32'h55B7D4C7, 4'd0,  6'd32, 32'hBCC0264D, 1'b0};
    vecs[1]  = '{32'h00000010, 32'h00000003, 4'd1,  6'd0,  32'h0000000D, 1'b0};
    vecs[2]  = '{32'hF0F0F0F0, 32'h0FF00FF0, 4'd2,  6'd0,  32'h00F000F0, 1'b0};
    vecs[3]  = '{32'hF0000000, 32'h0000000F, 4'd3,  6'd0,  32'hF000000F, 1'b0};
    vecs[4]  = '{32'hFFFF0000, 32'hFF00FF00, 4'd4,  6'd0,  32'h00FFFF00, 1'b0};
    vecs[5]  = '{32'h00000001, 32'h00000000, 4'd5,  6'd4,  32'h00000010, 1'b0};
    vecs[6]  = '{32'h00000001, 32'h00000000, 4'd5,  6'd40, 32'h00000000, 1'b0};
    vecs[7]  = '{32'h80000000, 32'h00000000, 4'd6,  6'd31, 32'h00000001, 1'b0};
    vecs[8]  = '{32'h80000000, 32'h00000000, 4'd7,  6'd4,  32'hF8000000, 1'b0};
    vecs[9]  = '{32'h80000001, 32'h00000000, 4'd8,  6'd1,  32'h00000003, 1'b0};
    vecs[10] = '{32'h00000001, 32'h00000000, 4'd9,  6'd1,  32'h80000000, 1'b0};
    vecs[11] = '{32'hFFFFFFFF, 32'h00000001, 4'd10, 6'd0,  32'h00000001, 1'b0};
    vecs[12] = '{32'hFFFFFFFF, 32'h00000000, 4'd11, 6'd0,  32'h00000000, 1'b1};
    vecs[13] = '{32'h00000001, 32'h00000001, 4'd0,  6'd0,  32'h00000002, 1'b0};
    vecs[14] = '{32'h12345678, 32'h00000000, 4'd15, 6'd63, 32'h00000000, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_level", 64'(fifo_level), 64'(0));
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_res_data", 64'(res_data), 64'(0));
    check("rst_res_err", 64'(res_err), 64'(0));
    check("rst_res_count", 64'(res_count), 64'(0));
    check("rst_alu", {alu_a, alu_b[21:0], alu_op, alu_n}, 64'(0));
    #1 rst_n = 1'b1;
    tick();
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));

    // Single command latency
    res_ready = 1'b1;
    drive(32'h67085186, 32'h55B7D4C7, 4'd0, 6'd32);
    tick();
    cmd_valid = 1'b0;
    check("t1_level_k", 64'(fifo_level), 64'(1));
    check("t1_valid_k", 64'(res_valid), 64'(0));
    tick();
    check("t1_alu_a", 64'(alu_a), 64'(32'h67085186));
    check("t1_alu_b", 64'(alu_b), 64'(32'h55B7D4C7));
    check("t1_alu_opn", 64'({alu_op, alu_n}), 64'({4'd0, 6'd32}));
    check("t1_valid_k1", 64'(res_valid), 64'(0));
    tick();
    check("t1_valid_k2", 64'(res_valid), 64'(1));
    check("t1_data", 64'(res_data), 64'(32'hBCC0264D));
    check("t1_err", 64'(res_err), 64'(0));
    tick();
    check("t1_count", 64'(res_count), 64'(1));
    check("t1_valid_after", 64'(res_valid), 64'(0));

    // Table vectors, one at a time with exact latency
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].n);
      tick();
      cmd_valid = 1'b0;
      tick();
      check($sformatf("vec%0d_alu_a", i), 64'(alu_a), 64'(vecs[i].a));
      check($sformatf("vec%0d_alu_opn", i), 64'({alu_b, alu_op, alu_n}),
            64'({vecs[i].b, vecs[i].op, vecs[i].n}));
      tick();
      check($sformatf("vec%0d_valid", i), 64'(res_valid), 64'(1));
      check($sformatf("vec%0d_data", i), 64'(res_data), 64'(vecs[i].exp_data));
      check($sformatf("vec%0d_err", i), 64'(res_err), 64'(vecs[i].exp_err));
      tick();
    end

    // Fill under backpressure, then push against a full FIFO while it pops
    for (int i = 0; i < 7; i++) begin
      fa[i]  = 32'h1000 + 32'(i) * 32'h111;
      fop[i] = 4'(i);
    end
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("fill%0d_ready", i), 64'(cmd_ready), 64'(1));
      drive(fa[i], 32'h10, fop[i], 6'(i + 1));
      tick();
    end
    cmd_valid = 1'b0;
    check("fill_level", 64'(fifo_level), 64'(4));
    check("fill_ready_low", 64'(cmd_ready), 64'(0));
    check("fill_res_valid", 64'(res_valid), 64'(1));
    check("fill_res_c0", 64'(res_data), 64'(exp_of(fa[0], 32'h10, fop[0], 6'd1)));
    repeat (3) tick();
    check("stall_res_c0", 64'(res_data), 64'(exp_of(fa[0], 32'h10, fop[0], 6'd1)));
    check("stall_alu_op", 64'(alu_op), 64'(1));
    check("stall_level", 64'(fifo_level), 64'(4));
    drive(fa[6], 32'h10, fop[6], 6'd7);
    res_ready = 1'b1;
    tick();
    check("full_pop_nopush_level", 64'(fifo_level), 64'(3));
    check("full_pop_res_c1", 64'(res_data), 64'(exp_of(fa[1], 32'h10, fop[1], 6'd2)));
    res_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    check("full_retry_level", 64'(fifo_level), 64'(4));
    res_ready = 1'b1;
    for (int i = 1; i < 7; i++) begin
      check($sformatf("drain%0d_valid", i), 64'(res_valid), 64'(1));
      check($sformatf("drain%0d_data", i), 64'(res_data),
            64'(exp_of(fa[i], 32'h10, fop[i], 6'(i + 1))));
      tick();
    end
    check("drain_done_valid", 64'(res_valid), 64'(0));
    check("drain_done_level", 64'(fifo_level), 64'(0));

    // Asynchronous reset with work queued
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(32'h100 + 32'(i), 32'h20, 4'd0, 6'd0);
      tick();
    end
    cmd_valid = 1'b0;
    check("pre_rst_level", 64'(fifo_level), 64'(3));
    check("pre_rst_valid", 64'(res_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("arst_level", 64'(fifo_level), 64'(0));
    check("arst_res", {31'd0, res_valid, res_err, res_data}, 64'(0));
    check("arst_count", 64'(res_count), 64'(0));
    check("arst_alu", {alu_a, alu_b[21:0], alu_op, alu_n}, 64'(0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    drive(32'h12345678, 32'h11111111, 4'd1, 6'd0);
    tick();
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    check("post_rst_valid_k1", 64'(res_valid), 64'(0));
    tick();
    check("post_rst_valid_k2", 64'(res_valid), 64'(1));
    check("post_rst_data", 64'(res_data), 64'(32'h01234567));
    tick();

    // Counter wrap on the CNT_W=2 instance
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    wrap_seq = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 5; i++) begin
      drive(32'(i), 32'hFF, 4'd2, 6'd0);
      tick();
      cmd_valid = 1'b0;
      repeat (3) tick();
      check($sformatf("wrap%0d_cnt2", i), 64'(u2_res_count), 64'(wrap_seq[i]));
      check($sformatf("wrap%0d_cnt16", i), 64'(res_count), 64'(i + 1));
    end

    // Randomized stream against the scoreboard
    for (int c = 0; c < 3000; c++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_a     = $urandom;
      cmd_b     = $urandom;
      cmd_op    = 4'($urandom_range(0, 15));
      cmd_n     = 6'($urandom_range(0, 63));
      res_ready = (c % 200 < 40) ? 1'b0 : ($urandom_range(0, 3) != 0);
      tick();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    repeat (12) tick();
    check("rand_sb_empty", 64'(exp_q.size()), 64'(0));
    check("rand_level_empty", 64'(fifo_level), 64'(0));
    check("rand_valid_low", 64'(res_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
